adder_accum_8b: RTL and testbench
=================================

# adder_accum_8b

Downstream consumer of the 8-bit adder stage. It takes each `{carry, sum}` result through a valid/ready handshake and accumulates `BATCH` results into a wide accumulator. It then presents the batch total with an overflow flag on a valid/ready output. It turns the combinational adder stream into a registered, flow-controlled batch result for the next stage.

## Interface
- `BATCH`, 8: number of adder results per batch; legal range ≥2.
- `ACC_W`, 16: accumulator and result width; legal range ≥10.
- `clk` input 1: the single clock for the block.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous abort; discards the batch in progress or the result being held.
- `in_valid` input 1: upstream adder result is valid.
- `in_ready` output 1: block accepts a result this cycle.
- `sum` input 8: adder sum.
- `carry` input 1: adder carry-out.
- `out_valid` output 1: `acc_out`/`ovf` hold a completed batch total.
- `out_ready` input 1: downstream accepts the result.
- `acc_out` output ACC_W: batch total.
- `ovf` output 1: the batch total exceeded ACC_W bits.

## Operation
- Each accepted sample has the value `{carry, sum}`, zero-extended to ACC_W bits (range 0..511).
- State machine `ACCUM`:
  - `in_ready=1`, `out_valid=0`.
  - A beat is accepted when `in_valid & in_ready`.
  - On each beat: `acc <= acc + sample`, `cnt <= cnt + 1`.
  - On the beat where `cnt == BATCH-1`: go to `DONE`.
- State machine `DONE`:
  - `in_ready=0`, `out_valid=1`.
  - `acc_out` and `ovf` are stable until the result is taken.
  - On `out_ready`: `acc <= 0`, `cnt <= 0`, `ovf <= 0`, go to `ACCUM`.
- Overflow, without SATURATE_EN (wrap mode):
  - The sum wraps modulo 2^ACC_W.
  - `ovf` is set by a carry out of bit ACC_W-1 and stays set until the batch ends.
- `clear`:
  - Has highest priority over all other inputs.
  - `acc`, `cnt` and `ovf` go to 0; next state is `ACCUM`.
  - A beat presented in the same cycle is not counted; upstream sees `in_ready=1` but the data is dropped.
  - A held result is dropped without a handshake.
- `acc_out` is driven directly from the accumulator register. In `ACCUM` it shows the running partial sum, which is don't-care to the consumer.

## Timing
- Reset values:
  - state `ACCUM`, `acc_out=0`, `ovf=0`, `out_valid=0`, `in_ready=1`.
  - Internal `cnt=0`.
- Latency: `out_valid` rises on the clock edge that accepts the final beat, so it is visible the cycle after that beat was presented.
- Throughput: one beat per cycle in `ACCUM`. A full batch occupies BATCH cycles plus at least one `DONE` cycle.
- Handshake rules:
  - `in_ready` and `out_valid` depend only on state, with no combinational path from `in_valid` or `out_ready`.
  - The block never issues `in_ready` and `out_valid` in the same cycle.
- Backpressure: `DONE` holds indefinitely while `out_ready=0`. Upstream stalls because `in_ready=0`.
- Asynchronous reset in mid-batch or in `DONE` returns immediately to the reset values, and partial data is lost.
- Counter `cnt` is ⌈log2(BATCH)⌉ bits wide. It never wraps, because the transition to `DONE` resets it.

## Configuration
- Macro `ADDER_ACCUM_SATURATE_EN`.
- Defined:
  - On overflow, `acc` clamps to 2^ACC_W-1 and stays there for the rest of the batch.
  - `ovf` is set on the first clamping beat.
- Undefined: wrap mode as described in Operation.
- Handshake and timing are identical in both modes.

## Structure
- Package `adder_accum_pkg` holds:
  - state enum `{ACCUM, DONE}`
  - `SAMPLE_W = 9`
  - default `BATCH` and `ACC_W` constants
- Natural sub-module: `accum_add_sat`. It is a combinational ACC_W adder that outputs the next accumulator value and an overflow bit, with saturation selected by the macro.
- The FSM and counter stay in the top module.

## Test plan
- Full batch, BATCH=8, ACC_W=16: 8 back-to-back beats of `sum=8'hFF`, `carry=1` -> `out_valid` one cycle after the last beat, `acc_out=16'h0FF8`, `ovf=0`.
- Wrap, ACC_W=10, BATCH=3, macro undefined: 3 beats of 0x1FF -> `acc_out=10'h1FD`, `ovf=1`.
- Saturate, same stimulus with `ADDER_ACCUM_SATURATE_EN` defined -> `acc_out=10'h3FF`, `ovf=1`.
- Backpressure: hold `out_ready=0` for 5 cycles after `DONE` with `in_valid=1` and `sum=8'h01` -> `in_ready=0` and `acc_out` stable throughout. Then `out_ready=1` -> the next batch starts from 0 and totals `BATCH*1`.
- Clear mid-batch: accept 3 beats of 0x10, pulse `clear` together with a 4th beat, then send 8 beats of 0x01 -> result `acc_out=8`, `ovf=0`.
- Async reset: drop `rst_n` mid-cycle during `DONE` -> `out_valid=0`, `acc_out=0` immediately, `in_ready=1` after release.

Source files
------------

// File: rtl/adder_accum_pkg.sv
// Shared types and constants for the adder result accumulator.
package adder_accum_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int SAMPLE_W  = 9;
    localparam int DEF_BATCH = 8;
    localparam int DEF_ACC_W = 16;

    // Counter width for a given batch size, never narrower than one bit.
    function automatic int cnt_width(input int batch);
        if (batch > 1) begin
            return $clog2(batch);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/adder_accum_8b_if.sv
// Input sample stream and output batch-result handshake of adder_accum_8b.
interface adder_accum_8b_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       sum;
    logic             carry;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;

    modport master (
        output in_valid, sum, carry, out_ready,
        input  in_ready, out_valid, acc_out, ovf
    );

    modport slave (
        input  in_valid, sum, carry, out_ready,
        output in_ready, out_valid, acc_out, ovf
    );
endinterface

// File: rtl/adder_accum_8b_accum_add_sat.sv
// Combinational accumulator adder; wraps by default, clamps when
// ADDER_ACCUM_SATURATE_EN is defined.
module accum_add_sat #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] sample,
    output logic [ACC_W-1:0] acc_next,
    output logic             ovf
);

    logic [ACC_W:0] raw_s;

    assign raw_s = {1'b0, acc} + {1'b0, sample};

    // Select the wrapped or clamped result and flag the carry out.
    always_comb begin
        ovf = raw_s[ACC_W];
`ifdef ADDER_ACCUM_SATURATE_EN
        if (raw_s[ACC_W]) begin
            acc_next = {ACC_W{1'b1}};
        end else begin
            acc_next = raw_s[ACC_W-1:0];
        end
`else
        acc_next = raw_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/adder_accum_8b.sv
// Accumulates BATCH {carry,sum} samples and presents the total on a
// valid/ready output. Overflow mode is chosen by ADDER_ACCUM_SATURATE_EN.
module adder_accum_8b
    import adder_accum_pkg::*;
#(
    parameter int BATCH = DEF_BATCH,
    parameter int ACC_W = DEF_ACC_W
) (
    input logic              clk,
    input logic              rst_n,
    input logic              clear,
    adder_accum_8b_if.slave  bus
);

    localparam int               CNT_W = cnt_width(BATCH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BATCH - 1);

    state_t           state_r;
    state_t           state_nx_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             ovf_r;
    logic             ovf_nx_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             beat_s;
    logic             last_s;
    logic [ACC_W-1:0] sample_s;
    logic [ACC_W-1:0] add_sum_s;
    logic             add_ovf_s;

    assign beat_s   = bus.in_valid & in_ready_r;
    assign last_s   = (cnt_r == LAST);
    assign sample_s = {{(ACC_W - SAMPLE_W){1'b0}}, bus.carry, bus.sum};

    accum_add_sat #(.ACC_W(ACC_W)) u_add (
        .acc      (acc_r),
        .sample   (sample_s),
        .acc_next (add_sum_s),
        .ovf      (add_ovf_s)
    );

    // Next-state decode; clear overrides every handshake.
    always_comb begin
        state_nx_s = state_r;
        if (clear) begin
            state_nx_s = ACCUM;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (beat_s && last_s) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = ACCUM;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_nx_s = ACCUM;
                    end else begin
                        state_nx_s = DONE;
                    end
                end
                default: state_nx_s = ACCUM;
            endcase
        end
    end

    // Accumulator, counter and sticky overflow update.
    always_comb begin
        acc_nx_s = acc_r;
        cnt_nx_s = cnt_r;
        ovf_nx_s = ovf_r;
        if (clear) begin
            acc_nx_s = {ACC_W{1'b0}};
            cnt_nx_s = {CNT_W{1'b0}};
            ovf_nx_s = 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (beat_s) begin
                        acc_nx_s = add_sum_s;
                        ovf_nx_s = ovf_r | add_ovf_s;
                        if (last_s) begin
                            cnt_nx_s = {CNT_W{1'b0}};
                        end else begin
                            cnt_nx_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        acc_nx_s = acc_r;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        acc_nx_s = {ACC_W{1'b0}};
                        cnt_nx_s = {CNT_W{1'b0}};
                        ovf_nx_s = 1'b0;
                    end else begin
                        acc_nx_s = acc_r;
                    end
                end
                default: begin
                    acc_nx_s = {ACC_W{1'b0}};
                    cnt_nx_s = {CNT_W{1'b0}};
                    ovf_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; handshake flags are registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            acc_r       <= acc_nx_s;
            cnt_r       <= cnt_nx_s;
            ovf_r       <= ovf_nx_s;
            in_ready_r  <= (state_nx_s == ACCUM);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.acc_out   = acc_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_adder_accum_8b.sv
// Directed scoreboard bench for adder_accum_8b: a default instance and a
// narrow BATCH=3/ACC_W=10 instance for overflow (wrap or saturate build).
module tb_adder_accum_8b;

    typedef struct {
        int          which;
        logic [15:0] acc;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clear_a;
    logic clear_b;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    adder_accum_8b_if #(.ACC_W(16)) bus_a ();
    adder_accum_8b_if #(.ACC_W(10)) bus_b ();

    adder_accum_8b #(.BATCH(8), .ACC_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_a),
        .bus   (bus_a)
    );

    adder_accum_8b #(.BATCH(3), .ACC_W(10)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] get_acc(input int which);
        if (which == 0) return bus_a.acc_out;
        else            return {6'd0, bus_b.acc_out};
    endfunction

    function automatic logic get_ovf(input int which);
        return (which == 0) ? bus_a.ovf : bus_b.ovf;
    endfunction

    function automatic logic get_ir(input int which);
        return (which == 0) ? bus_a.in_ready : bus_b.in_ready;
    endfunction

    function automatic logic get_ov(input int which);
        return (which == 0) ? bus_a.out_valid : bus_b.out_valid;
    endfunction

    task automatic set_in(input int which, input logic v, input logic [8:0] val);
        if (which == 0) begin
            bus_a.in_valid = v;
            {bus_a.carry, bus_a.sum} = val;
        end else begin
            bus_b.in_valid = v;
            {bus_b.carry, bus_b.sum} = val;
        end
    endtask

    task automatic set_oready(input int which, input logic r);
        if (which == 0) bus_a.out_ready = r;
        else            bus_b.out_ready = r;
    endtask

    // Reference: sum n copies of val into an accw-bit accumulator.
    task automatic push_exp(input int which, input int n, input logic [8:0] val, input int accw);
        longint acc;
        longint top;
        exp_t   e;
        acc = 0;
        top = (longint'(1) << accw) - 1;
        e.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc += longint'(val);
            if (acc > top) begin
                e.ovf = 1'b1;
`ifdef ADDER_ACCUM_SATURATE_EN
                acc = top;
`else
                acc -= (top + 1);
`endif
            end
        end
        e.which = which;
        e.acc   = acc[15:0];
        sb.push_back(e);
    endtask

    task automatic send_batch(input int which, input int n, input logic [8:0] val);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("beat_in_ready", 32'(get_ir(which)), 32'd1);
            chk("beat_no_out_valid", 32'(get_ov(which)), 32'd0);
            set_in(which, 1'b1, val);
        end
        @(negedge clk);
        set_in(which, 1'b0, 9'd0);
    endtask

    task automatic check_done(input int which);
        exp_t e;
        chk("done_out_valid", 32'(get_ov(which)), 32'd1);
        chk("done_in_ready", 32'(get_ir(which)), 32'd0);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL sb_underflow: observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk("result_inst", 32'(which), 32'(e.which));
            chk("result_acc", 32'(get_acc(which)), 32'(e.acc));
            chk("result_ovf", 32'(get_ovf(which)), 32'(e.ovf));
        end
    endtask

    task automatic release_out(input int which);
        set_oready(which, 1'b1);
        @(negedge clk);
        set_oready(which, 1'b0);
        chk("rel_out_valid", 32'(get_ov(which)), 32'd0);
        chk("rel_in_ready", 32'(get_ir(which)), 32'd1);
        chk("rel_acc_zero", 32'(get_acc(which)), 32'd0);
        chk("rel_ovf_zero", 32'(get_ovf(which)), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_a  = 1'b0;
        clear_b  = 1'b0;
        set_in(0, 1'b0, 9'd0);
        set_in(1, 1'b0, 9'd0);
        set_oready(0, 1'b0);
        set_oready(1, 1'b0);
        #12;
        for (int w = 0; w < 2; w++) begin
            chk("rst_in_ready", 32'(get_ir(w)), 32'd1);
            chk("rst_out_valid", 32'(get_ov(w)), 32'd0);
            chk("rst_acc", 32'(get_acc(w)), 32'd0);
            chk("rst_ovf", 32'(get_ovf(w)), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Full batch of 0x1FF on the 16-bit instance.
        push_exp(0, 8, 9'h1FF, 16);
        send_batch(0, 8, 9'h1FF);
        check_done(0);
        release_out(0);

        // Overflowing batch, then a clean batch proving ovf was cleared.
        push_exp(1, 3, 9'h1FF, 10);
        send_batch(1, 3, 9'h1FF);
        check_done(1);
        release_out(1);
        push_exp(1, 3, 9'h100, 10);
        send_batch(1, 3, 9'h100);
        check_done(1);
        release_out(1);

        // Backpressure: result must hold while upstream keeps offering data.
        push_exp(0, 8, 9'h020, 16);
        send_batch(0, 8, 9'h020);
        check_done(0);
        set_in(0, 1'b1, 9'h001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus_a.out_valid), 32'd1);
            chk("bp_acc_stable", 32'(bus_a.acc_out), 32'h0100);
        end
        set_oready(0, 1'b1);
        @(negedge clk);
        set_oready(0, 1'b0);
        set_in(0, 1'b0, 9'd0);
        chk("bp_rel_acc", 32'(bus_a.acc_out), 32'd0);
        push_exp(0, 8, 9'h001, 16);
        send_batch(0, 8, 9'h001);
        check_done(0);
        release_out(0);

        // Clear mid-batch together with a beat that must be dropped.
        send_batch(0, 3, 9'h010);
        chk("clr_pre_out_valid", 32'(bus_a.out_valid), 32'd0);
        set_in(0, 1'b1, 9'h010);
        clear_a = 1'b1;
        #1;
        chk("clr_in_ready", 32'(bus_a.in_ready), 32'd1);
        @(negedge clk);
        clear_a = 1'b0;
        set_in(0, 1'b0, 9'd0);
        chk("clr_acc", 32'(bus_a.acc_out), 32'd0);
        chk("clr_out_valid", 32'(bus_a.out_valid), 32'd0);
        push_exp(0, 8, 9'h001, 16);
        send_batch(0, 8, 9'h001);
        check_done(0);
        release_out(0);

        // Clear while a result is held drops it without a handshake.
        send_batch(0, 8, 9'h002);
        chk("clrd_held", 32'(bus_a.out_valid), 32'd1);
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        chk("clrd_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("clrd_in_ready", 32'(bus_a.in_ready), 32'd1);
        chk("clrd_acc", 32'(bus_a.acc_out), 32'd0);
        push_exp(0, 8, 9'h003, 16);
        send_batch(0, 8, 9'h003);
        check_done(0);
        release_out(0);

        // Asynchronous reset while in DONE.
        send_batch(0, 8, 9'h1FF);
        chk("ar_held", 32'(bus_a.out_valid), 32'd1);
        chk("ar_held_acc", 32'(bus_a.acc_out), 32'h0FF8);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("ar_acc", 32'(bus_a.acc_out), 32'd0);
        chk("ar_ovf", 32'(bus_a.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_post_in_ready", 32'(bus_a.in_ready), 32'd1);
        chk("ar_post_out_valid", 32'(bus_a.out_valid), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
